// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester arbiter and sequencer for the shared 64K x 16 data memory.
// Port 0 is the CPU data port. Port 1 is the audio DMA streamer. The write
// and read channels are arbitrated independently with round-robin priority.
// A lock lets one port hold exclusive access for an atomic read-modify-write.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   req_valid/write/lock per-port request qualifiers (bit p = port p)
//   req_addr, req_wdata per-port address/data, port p at [p*W +: W]
//   req_ready           per-port combinational grant (accept = valid & ready)
//   rsp_valid           per-port one-cycle read-response strobe
//   rsp_rdata           read data (mem_q passed straight through)
//   lock_abort          one-cycle pulse when a lock times out
//   mem_*               write port, read address and read data of the memory
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [1:0]          req_lock,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                lock_abort,
  output logic [ADDR_W-1:0]   mem_wraddress,
  output logic                mem_wren,
  output logic [DATA_W-1:0]   mem_data,
  output logic [ADDR_W-1:0]   mem_rdaddress,
  input  logic [DATA_W-1:0]   mem_q
);

  localparam int TW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_t;

  lock_state_t       state, state_next;
  logic              wr_ptr, rd_ptr;
  logic [TW-1:0]     lock_timer;
  logic [1:0]        rd_grant_q;
  logic [1:0]        allow, wr_cand, rd_cand, wr_grant, rd_grant;
  logic              owner, owner_write, owner_relock, timer_at_max;
  logic              lock_timeout, timer_clear, timer_inc;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;

  assign addr0  = req_addr[0 +: ADDR_W];
  assign addr1  = req_addr[ADDR_W +: ADDR_W];
  assign wdata0 = req_wdata[0 +: DATA_W];
  assign wdata1 = req_wdata[DATA_W +: DATA_W];

  // A lone candidate wins outright; the pointer only breaks a tie.
  function automatic logic [1:0] pick(input logic [1:0] cand, input logic ptr);
    if (cand == 2'b11) return ptr ? 2'b10 : 2'b01;
    return cand;
  endfunction

  // While a lock is held the other port is masked out of both channels,
  // so the owner is the only possible candidate and always wins.
  always_comb begin
    allow = 2'b11;
    if (state == LOCK0)      allow = 2'b01;
    else if (state == LOCK1) allow = 2'b10;
    wr_cand  = req_valid &  req_write & allow;
    rd_cand  = req_valid & ~req_write & allow;
    wr_grant = pick(wr_cand, wr_ptr);
    rd_grant = pick(rd_cand, rd_ptr);
  end

  assign owner        = (state == LOCK1);
  assign owner_write  = wr_grant[owner];
  assign owner_relock = rd_grant[owner] & req_lock[owner];
  assign timer_at_max = (lock_timer == TW'(LOCK_MAX));

  // State register. The pointer moves to the other port after any grant
  // (grant to port 0 -> pointer 1, grant to port 1 -> pointer 0).
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      lock_timer <= '0;
      rd_grant_q <= 2'b00;
    end else begin
      state <= state_next;
      if (|wr_grant) wr_ptr <= wr_grant[0];
      if (|rd_grant) rd_ptr <= rd_grant[0];
      if (timer_clear)    lock_timer <= '0;
      else if (timer_inc) lock_timer <= lock_timer + TW'(1);
      rd_grant_q <= rd_grant;
    end
  end

  // Next-state logic. The unlocking write has priority; a repeated locked
  // read restarts the timer; otherwise the lock times out at LOCK_MAX.
  always_comb begin
    state_next   = state;
    timer_clear  = 1'b0;
    timer_inc    = 1'b0;
    lock_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (rd_grant[0] && req_lock[0]) begin
          state_next  = LOCK0;
          timer_clear = 1'b1;
        end else if (rd_grant[1] && req_lock[1]) begin
          state_next  = LOCK1;
          timer_clear = 1'b1;
        end
      end
      LOCK0, LOCK1: begin
        if (owner_write) begin
          state_next = IDLE;
        end else if (owner_relock) begin
          timer_clear = 1'b1;
        end else if (timer_at_max) begin
          state_next   = IDLE;
          lock_timeout = 1'b1;
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs. A port never reads and writes in the same cycle, so the two
  // grant vectors never overlap on one bit.
  always_comb begin
    req_ready     = wr_grant | rd_grant;
    lock_abort    = lock_timeout;
    mem_wren      = |wr_grant;
    mem_wraddress = '0;
    mem_data      = '0;
    if (wr_grant[1]) begin
      mem_wraddress = addr1;
      mem_data      = wdata1;
    end else if (wr_grant[0]) begin
      mem_wraddress = addr0;
      mem_data      = wdata0;
    end
    mem_rdaddress = '0;
    if (rd_grant[1])      mem_rdaddress = addr1;
    else if (rd_grant[0]) mem_rdaddress = addr0;
    rsp_valid = rd_grant_q;
    rsp_rdata = mem_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. A simple write-first RAM sits on the memory
// side. A reference model tracks pointers, lock owner, lock timer and memory
// contents from the arbitration rules and checks every DUT output each cycle;
// the directed sequences add literal expectations at key cycles.
module tb_mem_arbiter;

  localparam int LOCK_MAX = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_write, req_lock;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_ready, rsp_valid;
  logic [15:0] rsp_rdata;
  logic        lock_abort;
  logic [15:0] mem_wraddress, mem_data, mem_rdaddress;
  logic        mem_wren;
  logic [15:0] ram_q;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(LOCK_MAX)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .lock_abort(lock_abort),
    .mem_wraddress(mem_wraddress), .mem_wren(mem_wren), .mem_data(mem_data),
    .mem_rdaddress(mem_rdaddress), .mem_q(ram_q)
  );

  always #5 clock = ~clock;

  // Initial memory image shared by the RAM and the reference model.
  function automatic logic [15:0] preload(input logic [15:0] a);
    if (a == 16'h0200) return 16'h0005;
    return a ^ 16'hA5A5;
  endfunction

  function automatic int pick(input bit c0, input bit c1, input int ptr);
    if (c0 && c1) return ptr;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                               input logic [15:0] a0, input logic [15:0] a1,
                               input logic [15:0] d0, input logic [15:0] d1);
    @(posedge clock);
    #1;
    req_valid = v;
    req_write = w;
    req_lock  = l;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  // Write-first RAM: requests are sampled mid-cycle and applied at the next
  // rising edge, write before read, so q reflects a same-address write.
  logic [15:0] sim_mem [65536];
  initial begin : ram
    logic        pend_we;
    logic [15:0] pend_wa, pend_wd, pend_ra;
    for (int i = 0; i < 65536; i++) sim_mem[i] = preload(16'(i));
    ram_q = 16'h0000;
    forever begin
      @(negedge clock);
      pend_we = mem_wren;
      pend_wa = mem_wraddress;
      pend_wd = mem_data;
      pend_ra = mem_rdaddress;
      @(posedge clock);
      if (pend_we === 1'b1) sim_mem[pend_wa] = pend_wd;
      ram_q = sim_mem[pend_ra];
    end
  end

  // Reference model and per-cycle comparison.
  logic [15:0] ref_mem [65536];
  initial begin : model
    int          m_wptr, m_rptr, m_owner, m_cnt, m_rsp;
    logic [15:0] m_rsp_data;
    int          wg, rg;
    bit [1:0]    allowed, er, erv;
    bit          owner_lock, timeout;
    logic [15:0] addr_p [2];
    logic [15:0] wd_p [2];
    m_wptr = 0; m_rptr = 0; m_owner = -1; m_cnt = 0; m_rsp = -1; m_rsp_data = 16'h0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = preload(16'(i));
    forever begin
      @(negedge clock);
      addr_p[0] = req_addr[15:0];
      addr_p[1] = req_addr[31:16];
      wd_p[0]   = req_wdata[15:0];
      wd_p[1]   = req_wdata[31:16];
      allowed = 2'b11;
      if (m_owner == 0) allowed = 2'b01;
      if (m_owner == 1) allowed = 2'b10;
      wg = pick(allowed[0] && req_valid[0] && req_write[0],
                allowed[1] && req_valid[1] && req_write[1], m_wptr);
      rg = pick(allowed[0] && req_valid[0] && !req_write[0],
                allowed[1] && req_valid[1] && !req_write[1], m_rptr);
      er = 2'b00;
      if (wg >= 0) er[wg] = 1'b1;
      if (rg >= 0) er[rg] = 1'b1;
      owner_lock = (m_owner >= 0) ? req_lock[m_owner] : 1'b0;
      timeout = (m_owner >= 0) && (wg != m_owner) && !(rg == m_owner && owner_lock)
                && (m_cnt == LOCK_MAX);
      erv = 2'b00;
      if (m_rsp >= 0) erv[m_rsp] = 1'b1;

      checkOutput("m_ready", 32'(req_ready), 32'(er));
      checkOutput("m_rsp_valid", 32'(rsp_valid), 32'(erv));
      if (m_rsp >= 0) checkOutput("m_rsp_rdata", 32'(rsp_rdata), 32'(m_rsp_data));
      checkOutput("m_lock_abort", 32'(lock_abort), 32'(timeout));
      checkOutput("m_wren", 32'(mem_wren), (wg >= 0) ? 32'd1 : 32'd0);
      checkOutput("m_wraddr", 32'(mem_wraddress), (wg >= 0) ? 32'(addr_p[wg]) : 32'd0);
      checkOutput("m_wdata", 32'(mem_data), (wg >= 0) ? 32'(wd_p[wg]) : 32'd0);
      checkOutput("m_rdaddr", 32'(mem_rdaddress), (rg >= 0) ? 32'(addr_p[rg]) : 32'd0);

      // Memory is written regardless of reset; the read sees it (write-first).
      if (wg >= 0) ref_mem[addr_p[wg]] = wd_p[wg];
      if (reset) begin
        m_wptr = 0; m_rptr = 0; m_owner = -1; m_cnt = 0; m_rsp = -1;
      end else begin
        if (wg >= 0) m_wptr = 1 - wg;
        if (rg >= 0) m_rptr = 1 - rg;
        if (m_owner < 0) begin
          if (rg >= 0 && req_lock[rg]) begin
            m_owner = rg;
            m_cnt   = 0;
          end
        end else if (wg == m_owner) begin
          m_owner = -1;
        end else if (rg == m_owner && owner_lock) begin
          m_cnt = 0;
        end else if (m_cnt == LOCK_MAX) begin
          m_owner = -1;
        end else begin
          m_cnt++;
        end
        m_rsp = rg;
        if (rg >= 0) m_rsp_data = ref_mem[addr_p[rg]];
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [1:0]  grant_seq [4];
    logic [15:0] data_seq [4];
    int          abort_count;
    reset     = 1'b1;
    req_valid = 2'b00; req_write = 2'b00; req_lock = 2'b00;
    req_addr  = '0;    req_wdata = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #2;
    checkOutput("reset_ready", 32'(req_ready), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_lock_abort", 32'(lock_abort), 32'h0);
    checkOutput("reset_wren", 32'(mem_wren), 32'h0);
    checkOutput("reset_rdaddr", 32'(mem_rdaddress), 32'h0);

    // Both ports read continuously: alternating grants, responses a cycle later.
    grant_seq[0] = 2'b01; grant_seq[1] = 2'b10; grant_seq[2] = 2'b01; grant_seq[3] = 2'b10;
    data_seq[0]  = 16'hA5B5; data_seq[1] = 16'hA585; data_seq[2] = 16'hA5B5; data_seq[3] = 16'hA585;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) applyStimulus(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0);
      else       applyStimulus(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      #2;
      if (i < 4) checkOutput("rr_ready", 32'(req_ready), 32'(grant_seq[i]));
      if (i > 0) begin
        checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'(grant_seq[i-1]));
        checkOutput("rr_rsp_rdata", 32'(rsp_rdata), 32'(data_seq[i-1]));
      end
    end

    // Same-cycle write and read of one address: the read sees the new data.
    applyStimulus(2'b11, 2'b01, 2'b00, 16'h0100, 16'h0100, 16'hBEEF, 16'h0);
    #2;
    checkOutput("wf_ready", 32'(req_ready), 32'h3);
    checkOutput("wf_wdata", 32'(mem_data), 32'hBEEF);
    applyStimulus(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    #2;
    checkOutput("wf_rsp_valid", 32'(rsp_valid), 32'h2);
    checkOutput("wf_rsp_rdata", 32'(rsp_rdata), 32'hBEEF);

    // Port 0 locked read-modify-write while port 1 keeps reading.
    applyStimulus(2'b11, 2'b00, 2'b01, 16'h0200, 16'h0300, 16'h0, 16'h0);
    #2 checkOutput("lk_grant", 32'(req_ready), 32'h1);
    applyStimulus(2'b10, 2'b00, 2'b00, 16'h0, 16'h0300, 16'h0, 16'h0);
    #2 checkOutput("lk_block1", 32'(req_ready), 32'h0);
    checkOutput("lk_rsp_rdata", 32'(rsp_rdata), 32'h0005);
    applyStimulus(2'b10, 2'b00, 2'b00, 16'h0, 16'h0300, 16'h0, 16'h0);
    #2 checkOutput("lk_block2", 32'(req_ready), 32'h0);
    applyStimulus(2'b11, 2'b01, 2'b00, 16'h0200, 16'h0300, 16'h0006, 16'h0);
    #2 checkOutput("lk_unlock", 32'(req_ready), 32'h1);
    applyStimulus(2'b10, 2'b00, 2'b00, 16'h0, 16'h0300, 16'h0, 16'h0);
    #2 checkOutput("lk_resume", 32'(req_ready), 32'h2);
    applyStimulus(2'b01, 2'b00, 2'b00, 16'h0200, 16'h0, 16'h0, 16'h0);
    #2 checkOutput("lk_p1_rdata", 32'(rsp_rdata), 32'hA6A5);
    applyStimulus(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    #2 checkOutput("lk_rmw_rdata", 32'(rsp_rdata), 32'h0006);

    // Port 1 takes a lock and never writes: forced release after LOCK_MAX.
    applyStimulus(2'b10, 2'b00, 2'b10, 16'h0, 16'h0020, 16'h0, 16'h0);
    #2 checkOutput("to_grant", 32'(req_ready), 32'h2);
    abort_count = 0;
    for (int k = 1; k <= LOCK_MAX + 2; k++) begin
      applyStimulus(2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0);
      #2;
      if (lock_abort === 1'b1) abort_count++;
      if (k == LOCK_MAX + 1) checkOutput("to_abort", 32'(lock_abort), 32'h1);
      if (k <= LOCK_MAX + 1) checkOutput("to_blocked", 32'(req_ready), 32'h0);
      else                   checkOutput("to_resume", 32'(req_ready), 32'h1);
    end
    checkOutput("to_abort_count", 32'(abort_count), 32'd1);

    // Reset while port 0 holds a lock and a read is accepted in that cycle.
    applyStimulus(2'b01, 2'b00, 2'b01, 16'h0010, 16'h0, 16'h0, 16'h0);
    #2 checkOutput("rs_lock", 32'(req_ready), 32'h1);
    applyStimulus(2'b11, 2'b00, 2'b00, 16'h0020, 16'h0030, 16'h0, 16'h0);
    reset = 1'b1;
    #2 checkOutput("rs_locked_ready", 32'(req_ready), 32'h1);
    applyStimulus(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0, 16'h0);
    reset = 1'b0;
    #2 checkOutput("rs_rsp_suppressed", 32'(rsp_valid), 32'h0);
    checkOutput("rs_rd_ptr", 32'(req_ready), 32'h1);
    applyStimulus(2'b11, 2'b11, 2'b00, 16'h0400, 16'h0401, 16'h1234, 16'h5678);
    #2 checkOutput("rs_wr_ptr", 32'(req_ready), 32'h1);
    applyStimulus(2'b10, 2'b00, 2'b00, 16'h0, 16'h0020, 16'h0, 16'h0);
    #2 checkOutput("rs_idle", 32'(req_ready), 32'h2);

    // Port 1 alone writes 16 words, then port 0 reads them back.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(2'b10, 2'b10, 2'b00, 16'h0, 16'(i), 16'h0, 16'hC000 + 16'(i));
      #2 checkOutput("sw_ready", 32'(req_ready), 32'h2);
    end
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) applyStimulus(2'b01, 2'b00, 2'b00, 16'(i), 16'h0, 16'h0, 16'h0);
      else        applyStimulus(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      #2;
      if (i > 0) checkOutput("sw_readback", 32'(rsp_rdata), 32'hC000 + 32'(i - 1));
    end

    applyStimulus(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the shared 64K x 16 data memory (`modelsim_N_mem` / its FPGA equivalent: independent write and read ports, read address registered, `q` valid the cycle after the read is issued). It sits between the CPU data port (port 0) and the audio DMA streamer (port 1) and the memory. Read and write channels are arbitrated independently with round-robin priority. A lock mechanism gives a single port exclusive access for atomic read-modify-write sequences.

## Interface
- `ADDR_W`, 16, memory address width
- `DATA_W`, 16, memory data width
- `LOCK_MAX`, 64, maximum cycles a lock is held before forced release (>= 2)

- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  2  per-port request valid; bit p = port p
- `req_write`  in  2  per-port: 1 = write, 0 = read
- `req_lock`  in  2  per-port: on a read, acquire the lock
- `req_addr`  in  2*ADDR_W  per-port address; port p at bits [p*ADDR_W +: ADDR_W]
- `req_wdata`  in  2*DATA_W  per-port write data, same packing
- `req_ready`  out  2  per-port grant; the request is accepted when `valid & ready`
- `rsp_valid`  out  2  per-port read-response strobe, one cycle
- `rsp_rdata`  out  DATA_W  read data; meaningful only while some `rsp_valid` bit is 1
- `lock_abort`  out  1  one-cycle pulse when a lock times out
- `mem_wraddress`  out  ADDR_W  to memory `wraddress`
- `mem_wren`  out  1  to memory `wren`
- `mem_data`  out  DATA_W  to memory `data`
- `mem_rdaddress`  out  ADDR_W  to memory `rdaddress`
- `mem_q`  in  DATA_W  from memory `q`

## Operation
- Write channel: candidates are ports with `valid & write`. Read channel: candidates are ports with `valid & ~write`. Each channel grants at most one port per cycle.
- Each channel keeps its own priority pointer, reset to port 0. After a grant to port p, that channel's pointer becomes 1-p. If there is a single candidate, it is granted regardless of the pointer.
- `req_ready[p]` is combinational, and is 1 only when port p is valid and granted on its channel. A write by one port and a read by the other are accepted in the same cycle.
- Memory drive:
  - `mem_wren` = write grant.
  - `mem_wraddress`/`mem_data` = the granted port's fields, or 0 when there is no write grant.
  - `mem_rdaddress` = the granted reader's address, or 0 when idle.
- Response tracking: a registered 2-bit read-grant vector becomes `rsp_valid` in the next cycle. `rsp_rdata` = `mem_q` passed through combinationally. There is no response backpressure.
- Same-cycle write and read to the same address: the read returns the newly written data (write-first).
- Lock FSM, states IDLE, LOCK0, LOCK1:
  - IDLE -> LOCKp when a read from port p is accepted with `req_lock[p]` = 1.
  - In LOCKp: the other port's `req_ready` is forced to 0 on both channels. Port p is granted whenever it is valid.
  - LOCKp -> IDLE when a port-p write is accepted (the unlocking write).
  - LOCKp -> IDLE when the lock timer reaches `LOCK_MAX` with no port-p write accepted. That cycle pulses `lock_abort`.
  - The lock timer clears on entry to LOCKp and increments each cycle in LOCKp. A further locked read from port p while in LOCKp clears the timer and stays in LOCKp.
  - A simultaneous port-p locked read and port-p write cannot occur, because a port issues one request per cycle.
- Lock requests from both ports in the same IDLE cycle: the read pointer decides the winner. Only the granted port acquires the lock.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `lock_abort` = 0, `mem_wren` = 0.
  - Memory addresses and data = 0.
  - FSM = IDLE, both pointers = port 0, lock timer = 0, read-grant register = 0.
- Reset asserted mid-lock returns the FSM to IDLE at the next edge. The next-cycle `rsp_valid` of a read accepted in the reset cycle is suppressed.
- Read latency: accept in cycle t, `rsp_valid[p]` and data in cycle t+1. Back-to-back reads give one response per cycle.
- Write latency: the memory is updated at the edge ending the accept cycle.
- Lock grant of the other port resumes in the cycle after the unlocking write or after the `lock_abort` cycle.

## Test plan
- Reset, then both ports read (port 0 at 0x0010, port 1 at 0x0020) continuously for 4 cycles: grants go 0,1,0,1, each `rsp_valid` follows one cycle later, and the data matches the preloaded memory contents.
- Port 0 writes 0xBEEF to 0x0100 while port 1 reads 0x0100 in the same cycle: both `req_ready` are 1. Next cycle `rsp_valid` = 2'b10 with `rsp_rdata` = 0xBEEF.
- Port 0 issues a locked read of 0x0200 (memory holds 0x0005), then writes 0x0006 to 0x0200 three cycles later, while port 1 requests continuously:
  - `req_ready[1]` stays 0 from the cycle after the lock grant through the unlocking write.
  - Port 1 is granted in the following cycle.
- Port 1 takes a lock and never writes, with `LOCK_MAX` = 64: `lock_abort` pulses exactly once, 64 cycles after entry to LOCK1, and port 0 is granted in the next cycle.
- Reset asserted while in LOCK0 with a read accepted in the same cycle: the FSM is IDLE after the edge, `rsp_valid` stays 0, and both pointers are back at port 0.
- Single requester (port 1 writing 0x0000..0x000F, one word per cycle) with port 0 idle: `req_ready[1]` = 1 every cycle, and the memory holds all 16 words afterwards.
